io_uart_responder: RTL

//  Core-side I/O responder: accepts out_issued/out_data byte writes and in_issued reads from the pipeline core.

---
 rtl/io_pkg.sv | 19 +
 rtl/io_fifo.sv | 49 ++++
 rtl/io_uart_responder.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared constants and state type for the UART responder TX/RX paths.
package io_pkg;

    localparam int UART_DATA_BITS       = 8;

    localparam int STATUS_FRAME_ERR_BIT = 15;
    localparam int STATUS_OVERRUN_BIT   = 14;
    localparam int STATUS_RX_CNT_LSB    = 8;
    localparam int STATUS_TX_CNT_LSB    = 0;
    localparam int STATUS_CNT_W         = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/io_fifo.sv
// Show-ahead FIFO with occupancy count; dout is the current head, valid while !empty.
module io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: nothing reads it until a push has landed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst) !(pop && empty));

endmodule

// File: rtl/io_uart_responder.sv
// Core-side UART responder: byte FIFOs between the pipeline core and an 8N1 pin pair.
// Build option IO_LOOPBACK_EN: the RX synchroniser takes the internal TX line instead of uart_rx.
//
// state | meaning (same encoding for TX and RX FSMs)
// IDLE  | line idle; TX waits for a queued byte, RX waits for a falling edge
// START | start bit; RX re-checks the line at half a bit to reject glitches
// DATA  | eight data bits, LSB first, one bit timer period each
// STOP  | stop bit; TX chains straight into START when more bytes are queued
module io_uart_responder
    import io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        out_issued,
    input  logic [31:0] out_data,
    output logic        out_stall,
    input  logic        in_issued,
    output logic [31:0] in_data,
    output logic        in_stall,
    output logic [31:0] status,
    input  logic        uart_rx,
    output logic        uart_tx
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(UART_DATA_BITS);
    localparam logic [TMR_W-1:0] BIT_TICKS  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0] HALF_TICKS = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(UART_DATA_BITS - 1);

    logic [7:0]       tx_head, rx_head;
    logic [CNT_W-1:0] tx_cnt, rx_cnt;
    logic             tx_full, tx_empty, rx_full, rx_empty;
    logic             tx_pop, rx_push;

    uart_state_t      tx_state, tx_state_n;
    logic [TMR_W-1:0] tx_timer, tx_timer_n;
    logic [BIT_W-1:0] tx_bits, tx_bits_n;
    logic [7:0]       tx_shift, tx_shift_n;
    logic             tx_line;

    uart_state_t      rx_state, rx_state_n;
    logic [TMR_W-1:0] rx_timer, rx_timer_n;
    logic [BIT_W-1:0] rx_bits, rx_bits_n;
    logic [7:0]       rx_shift, rx_shift_n;
    logic [1:0]       rx_sync;
    logic             rx_src, rx_s, rx_prev;
    logic             frame_err, overrun, frame_set, overrun_set;
    logic             unused_in;

    io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (out_issued && !tx_full),
        .pop   (tx_pop),
        .din   (out_data[7:0]),
        .dout  (tx_head),
        .count (tx_cnt),
        .full  (tx_full),
        .empty (tx_empty)
    );

    io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (in_issued && !rx_empty),
        .din   (rx_shift),
        .dout  (rx_head),
        .count (rx_cnt),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= IDLE;
            tx_timer <= '0;
            tx_bits  <= '0;
            tx_shift <= '0;
            rx_state <= IDLE;
            rx_timer <= '0;
            rx_bits  <= '0;
            rx_shift <= '0;
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_timer <= tx_timer_n;
            tx_bits  <= tx_bits_n;
            tx_shift <= tx_shift_n;
            rx_state <= rx_state_n;
            rx_timer <= rx_timer_n;
            rx_bits  <= rx_bits_n;
            rx_shift <= rx_shift_n;
            rx_sync  <= {rx_sync[0], rx_src};
            rx_prev  <= rx_s;
            frame_err <= frame_err | frame_set;
            overrun   <= overrun | overrun_set;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_timer_n = tx_timer;
        tx_bits_n  = tx_bits;
        tx_shift_n = tx_shift;
        tx_pop     = 1'b0;
        unique case (tx_state)
            IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_head;
                    tx_timer_n = BIT_TICKS;
                    tx_state_n = START;
                end
            end
            START: begin
                if (tx_timer == '0) begin
                    tx_timer_n = BIT_TICKS;
                    tx_bits_n  = '0;
                    tx_state_n = DATA;
                end else tx_timer_n = tx_timer - 1'b1;
            end
            DATA: begin
                if (tx_timer == '0) begin
                    tx_timer_n = BIT_TICKS;
                    tx_shift_n = tx_shift >> 1;
                    tx_bits_n  = tx_bits + 1'b1;
                    if (tx_bits == LAST_BIT) tx_state_n = STOP;
                end else tx_timer_n = tx_timer - 1'b1;
            end
            STOP: begin
                if (tx_timer == '0) begin
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_n = tx_head;
                        tx_timer_n = BIT_TICKS;
                        tx_state_n = START;
                    end else tx_state_n = IDLE;
                end else tx_timer_n = tx_timer - 1'b1;
            end
        endcase
    end

    // Decoded straight from reset-cleared state so the line goes high the moment rst drops.
    assign tx_line = (tx_state == START) ? 1'b0 :
                     (tx_state == DATA)  ? tx_shift[0] : 1'b1;
    assign uart_tx = tx_line;

`ifdef IO_LOOPBACK_EN
    assign rx_src    = tx_line;
    assign unused_in = ^{out_data[31:8], uart_rx};
`else
    assign rx_src    = uart_rx;
    assign unused_in = ^out_data[31:8];
`endif

    assign rx_s = rx_sync[1];

    always_comb begin
        rx_state_n  = rx_state;
        rx_timer_n  = rx_timer;
        rx_bits_n   = rx_bits;
        rx_shift_n  = rx_shift;
        rx_push     = 1'b0;
        frame_set   = 1'b0;
        overrun_set = 1'b0;
        unique case (rx_state)
            IDLE: begin
                if (rx_prev && !rx_s) begin
                    rx_timer_n = HALF_TICKS;
                    rx_state_n = START;
                end
            end
            START: begin
                if (rx_timer == '0) begin
                    rx_timer_n = BIT_TICKS;
                    rx_bits_n  = '0;
                    rx_state_n = rx_s ? IDLE : DATA;
                end else rx_timer_n = rx_timer - 1'b1;
            end
            DATA: begin
                if (rx_timer == '0) begin
                    rx_timer_n = BIT_TICKS;
                    rx_shift_n = {rx_s, rx_shift[7:1]};
                    rx_bits_n  = rx_bits + 1'b1;
                    if (rx_bits == LAST_BIT) rx_state_n = STOP;
                end else rx_timer_n = rx_timer - 1'b1;
            end
            STOP: begin
                if (rx_timer == '0) begin
                    rx_state_n = IDLE;
                    if (!rx_s)       frame_set   = 1'b1;
                    else if (rx_full) overrun_set = 1'b1;
                    else             rx_push     = 1'b1;
                end else rx_timer_n = rx_timer - 1'b1;
            end
        endcase
    end

    assign out_stall = tx_full;
    assign in_stall  = rx_empty;
    assign in_data   = {24'b0, rx_empty ? 8'h00 : rx_head};

    always_comb begin
        status = '0;
        status[STATUS_FRAME_ERR_BIT] = frame_err;
        status[STATUS_OVERRUN_BIT]   = overrun;
        status[STATUS_RX_CNT_LSB +: STATUS_CNT_W] = STATUS_CNT_W'(rx_cnt);
        status[STATUS_TX_CNT_LSB +: STATUS_CNT_W] = STATUS_CNT_W'(tx_cnt);
    end

endmodule
